// File: rtl/shot_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : shot_ctrl
// Summary  : Single-projectile sequencer (IDLE -> FLY -> COOL -> IDLE).
//            Optional macro SHOT_BOUNCE_EN reflects the shot off the side walls
//            instead of terminating it.
// Revision : 1.0  initial release
// ============================================================================
module shot_ctrl #(
    parameter int X_MAX    = 31,
    parameter int Y_MAX    = 31,
    parameter int COOLDOWN = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ena,
    input  logic       fire,
    input  logic [4:0] x_pos,
    input  logic [4:0] run,
    input  logic [4:0] rise,
    input  logic       dir,
    input  logic       hit,
    output logic       shot_active,
    output logic [4:0] shot_x,
    output logic [4:0] shot_y,
    output logic       shot_done,
    output logic       ready
);

    localparam int                 c_CNT_W    = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(COOLDOWN - 1);
    localparam logic [5:0]         c_X_MAX    = 6'(X_MAX);
    localparam logic [5:0]         c_Y_MAX    = 6'(Y_MAX);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FLY  = 2'd1,
        S_COOL = 2'd2
    } state_t;

    state_t             r_state;
    logic [4:0]         r_run;
    logic [4:0]         r_rise;
    logic               r_dir;
    logic [c_CNT_W-1:0] r_cnt;

    logic [5:0] w_y_next;
    logic [5:0] w_x_sum;
    logic [4:0] w_x_step;
    logic       w_wall;
    logic       w_stop;

    // Next-move arithmetic is done one bit wider so edge overruns are visible.
    assign w_y_next = {1'b0, shot_y} + {1'b0, r_rise};
    assign w_x_sum  = {1'b0, shot_x} + {1'b0, r_run};
    assign w_wall   = r_dir ? (w_x_sum > c_X_MAX) : (r_run > shot_x);
    assign w_x_step = r_dir ? w_x_sum[4:0] : (shot_x - r_run);

`ifdef SHOT_BOUNCE_EN
    localparam logic [5:0] c_X_TWICE = 6'(2 * X_MAX);
    logic [4:0] w_x_bounce;
    assign w_x_bounce = r_dir ? 5'(c_X_TWICE - w_x_sum) : (r_run - shot_x);
    assign w_stop     = hit | (w_y_next > c_Y_MAX);
`else
    assign w_stop     = hit | (w_y_next > c_Y_MAX) | w_wall;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            shot_x      <= 5'd0;
            shot_y      <= 5'd0;
            shot_active <= 1'b0;
            shot_done   <= 1'b0;
            ready       <= 1'b1;
            r_cnt       <= '0;
            r_run       <= 5'd0;
            r_rise      <= 5'd0;
            r_dir       <= 1'b0;
        end else begin
            shot_done <= 1'b0;
            if (ena) begin
                case (r_state)
                    S_IDLE: begin
                        if (fire) begin
                            r_state     <= S_FLY;
                            shot_active <= 1'b1;
                            ready       <= 1'b0;
                            shot_x      <= x_pos;
                            shot_y      <= 5'd0;
                            r_run       <= run;
                            r_rise      <= (rise == 5'd0) ? 5'd1 : rise;
                            r_dir       <= dir;
                        end
                    end
                    S_FLY: begin
                        if (w_stop) begin
                            r_state     <= S_COOL;
                            shot_active <= 1'b0;
                            shot_done   <= 1'b1;
                            r_cnt       <= '0;
                        end else begin
                            shot_y <= w_y_next[4:0];
`ifdef SHOT_BOUNCE_EN
                            if (w_wall) begin
                                shot_x <= w_x_bounce;
                                r_dir  <= ~r_dir;
                            end else begin
                                shot_x <= w_x_step;
                            end
`else
                            shot_x <= w_x_step;
`endif
                        end
                    end
                    S_COOL: begin
                        if (r_cnt == c_CNT_LAST) begin
                            r_state <= S_IDLE;
                            ready   <= 1'b1;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    default: begin
                        r_state     <= S_IDLE;
                        shot_active <= 1'b0;
                        ready       <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_shot_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_shot_ctrl
// Summary  : Scoreboard bench for shot_ctrl against a geometric shot model.
// Revision : 1.0  initial release
// ============================================================================
module tb_shot_ctrl;

    localparam int X_MAX    = 31;
    localparam int Y_MAX    = 31;
    localparam int COOLDOWN = 4;

    logic       clk;
    logic       reset_n;
    logic       ena;
    logic       fire;
    logic [4:0] x_pos;
    logic [4:0] run;
    logic [4:0] rise;
    logic       dir;
    logic       hit;
    logic       shot_active;
    logic [4:0] shot_x;
    logic [4:0] shot_y;
    logic       shot_done;
    logic       ready;

    shot_ctrl #(
        .X_MAX    (X_MAX),
        .Y_MAX    (Y_MAX),
        .COOLDOWN (COOLDOWN)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .ena         (ena),
        .fire        (fire),
        .x_pos       (x_pos),
        .run         (run),
        .rise        (rise),
        .dir         (dir),
        .hit         (hit),
        .shot_active (shot_active),
        .shot_x      (shot_x),
        .shot_y      (shot_y),
        .shot_done   (shot_done),
        .ready       (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit       active;
        bit [4:0] x;
        bit [4:0] y;
        bit       done;
        bit       rdy;
    } exp_t;

    exp_t  sb[$];
    int    checks = 0;
    int    errors = 0;
    string scen   = "reset";

    // Reference model: shot as a point with integer coordinates and a velocity.
    bit m_ready, m_active, m_done, m_dir;
    int m_x, m_y, m_run, m_rise, m_cool;

    function void model_reset();
        m_ready = 1; m_active = 0; m_done = 0; m_dir = 0;
        m_x = 0; m_y = 0; m_run = 0; m_rise = 0; m_cool = 0;
    endfunction

    function void model_step();
        int nx, ny;
        bit stop;
        m_done = 0;
        if (!ena) return;
        if (m_ready) begin
            if (fire) begin
                m_ready  = 0;
                m_active = 1;
                m_x      = int'(x_pos);
                m_y      = 0;
                m_run    = int'(run);
                m_rise   = (rise == 0) ? 1 : int'(rise);
                m_dir    = dir;
            end
        end else if (m_active) begin
            ny   = m_y + m_rise;
            nx   = m_dir ? m_x + m_run : m_x - m_run;
            stop = hit || (ny > Y_MAX);
            if (!stop && (nx < 0 || nx > X_MAX)) begin
`ifdef SHOT_BOUNCE_EN
                nx    = (nx < 0) ? -nx : 2 * X_MAX - nx;
                m_dir = !m_dir;
`else
                stop  = 1;
`endif
            end
            if (stop) begin
                m_active = 0;
                m_done   = 1;
                m_cool   = COOLDOWN;
            end else begin
                m_x = nx;
                m_y = ny;
            end
        end else begin
            m_cool = m_cool - 1;
            if (m_cool == 0) m_ready = 1;
        end
    endfunction

    function void push_exp();
        exp_t e;
        e.active = m_active;
        e.x      = 5'(m_x);
        e.y      = 5'(m_y);
        e.done   = m_done;
        e.rdy    = m_ready;
        sb.push_back(e);
    endfunction

    // Monitor: one expected snapshot per clock in which stimulus was issued.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (shot_active !== e.active || shot_x !== e.x || shot_y !== e.y ||
                shot_done !== e.done || ready !== e.rdy) begin
                errors++;
                $display("FAIL %s t=%0t: got act=%b x=%0d y=%0d done=%b rdy=%b, want act=%b x=%0d y=%0d done=%b rdy=%b",
                         scen, $time, shot_active, shot_x, shot_y, shot_done, ready,
                         e.active, e.x, e.y, e.done, e.rdy);
            end
        end
    end

    task automatic tick(input logic e, input logic f, input logic h);
        ena  = e;
        fire = f;
        hit  = h;
        @(posedge clk);
        model_step();
        push_exp();
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        model_reset();
        push_exp();
        @(negedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic run_until_ready();
        for (int i = 0; i < 200 && !m_ready; i++) tick(1'b1, 1'b0, 1'b0);
        if (!m_ready) begin
            checks++;
            errors++;
            $display("FAIL %s: model never returned to ready within 200 ticks", scen);
        end
    endtask

    task automatic set_aim(input int xp, input int rn, input int rs, input bit d);
        x_pos = 5'(xp);
        run   = 5'(rn);
        rise  = 5'(rs);
        dir   = d;
    endtask

    initial begin
        reset_n = 1'b0;
        ena = 1'b0; fire = 1'b0; hit = 1'b0;
        set_aim(0, 0, 1, 1'b0);
        model_reset();
        do_reset();

        scen = "straight_up";
        set_aim(10, 0, 1, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        run_until_ready();

        scen = "aim_latched";
        set_aim(10, 1, 2, 1'b1);
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        set_aim(3, 2, 1, 1'b0);
        run_until_ready();

        scen = "hit_and_cool";
        set_aim(5, 1, 1, 1'b1);
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b1);
        repeat (6) tick(1'b1, 1'b1, 1'b0);
        run_until_ready();

        scen = "left_wall";
        set_aim(1, 2, 1, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        repeat (4) tick(1'b1, 1'b0, 1'b0);
        run_until_ready();

        scen = "right_wall_stall";
        set_aim(31, 2, 1, 1'b1);
        tick(1'b1, 1'b1, 1'b0);
        repeat (20) tick(1'b0, 1'b0, 1'b0);
        run_until_ready();

        scen = "rise_zero";
        set_aim(0, 2, 0, 1'b1);
        tick(1'b1, 1'b1, 1'b0);
        run_until_ready();

        scen = "reset_mid_fly";
        set_aim(12, 1, 1, 1'b1);
        tick(1'b1, 1'b1, 1'b0);
        repeat (3) tick(1'b1, 1'b0, 1'b0);
        do_reset();
        tick(1'b1, 1'b0, 1'b0);

        scen = "random";
        for (int i = 0; i < 1500; i++) begin
            set_aim(int'($urandom_range(0, 31)), int'($urandom_range(0, 2)),
                    int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
            tick(1'($urandom_range(0, 9) < 8), 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 19) == 0));
        end

        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d entries left in scoreboard, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
